// File: rtl/vga_timing_if.sv
// VGA timing output bundle: counters, syncs, blanking and line/frame strobes.
// The timing generator drives it through the master modport; consumers such as
// a pixel pipeline or DAC wrapper read it through the slave modport.
interface vga_timing_if;
   logic       vga_clk;
   logic       pix_en;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       hsync_n;
   logic       vsync_n;
   logic       blank_n;
   logic       sync_n;
   logic       line_end;
   logic       frame_end;

   modport master (
      output vga_clk,
      output pix_en,
      output hcnt,
      output vcnt,
      output hsync_n,
      output vsync_n,
      output blank_n,
      output sync_n,
      output line_end,
      output frame_end
   );

   modport slave (
      input vga_clk,
      input pix_en,
      input hcnt,
      input vcnt,
      input hsync_n,
      input vsync_n,
      input blank_n,
      input sync_n,
      input line_end,
      input frame_end
   );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator, 640x480@60 by default, running from a 50 MHz clk.
// A phase bit divides clk by two: it is the pixel enable and also the 25 MHz
// pixel clock sent to the DAC. That clock rises one clk after the counters
// step, so the DAC samples in the middle of each pixel.
// Syncs, blanking and the line/frame strobes are registered. They are computed
// from the next-state counter values, so each one changes on the same edge as
// hcnt/vcnt and has no lag relative to them.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic          clk,
   input  logic          reset,
   vga_timing_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic       ph_q, ph_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       hsync_n_q, hsync_n_d;
   logic       vsync_n_q, vsync_n_d;
   logic       blank_n_q, blank_n_d;
   logic       line_end_q, line_end_d;
   logic       frame_end_q, frame_end_d;

   // Next-state counters: step on pixel-enable cycles, wrap at the line and frame totals.
   always_comb begin
      ph_d   = ~ph_q;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (ph_q) begin
         if (hcnt_q == H_MAX) begin
            hcnt_d = 10'd0;
            if (vcnt_q == V_MAX) begin
               vcnt_d = 10'd0;
            end else begin
               vcnt_d = vcnt_q + 10'd1;
            end
         end else begin
            hcnt_d = hcnt_q + 10'd1;
            vcnt_d = vcnt_q;
         end
      end else begin
         hcnt_d = hcnt_q;
         vcnt_d = vcnt_q;
      end
   end

   // Decode the next counter state so the registered syncs and strobes line up with the counters.
   always_comb begin
      hsync_n_d   = !((hcnt_d >= HS_START) && (hcnt_d < HS_END));
      vsync_n_d   = !((vcnt_d >= VS_START) && (vcnt_d < VS_END));
      blank_n_d   = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
      line_end_d  = ph_d && (hcnt_d == H_MAX);
      frame_end_d = ph_d && (hcnt_d == H_MAX) && (vcnt_d == V_MAX);
   end

   // State and output registers; reset returns to the top-left, idle phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph_q        <= 1'b0;
         hcnt_q      <= 10'd0;
         vcnt_q      <= 10'd0;
         hsync_n_q   <= 1'b1;
         vsync_n_q   <= 1'b1;
         blank_n_q   <= 1'b1;
         line_end_q  <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         ph_q        <= ph_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         hsync_n_q   <= hsync_n_d;
         vsync_n_q   <= vsync_n_d;
         blank_n_q   <= blank_n_d;
         line_end_q  <= line_end_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign vga.vga_clk   = ph_q;
   assign vga.pix_en    = ph_q;
   assign vga.hcnt      = hcnt_q;
   assign vga.vcnt      = vcnt_q;
   assign vga.hsync_n   = hsync_n_q;
   assign vga.vsync_n   = vsync_n_q;
   assign vga.blank_n   = blank_n_q;
   assign vga.sync_n    = 1'b0;
   assign vga.line_end  = line_end_q;
   assign vga.frame_end = frame_end_q;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (pixel/line counts, 640x480@60 from 50 MHz).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk in 1: 50 MHz system clock (CLOCK_50 domain).
- reset in 1: synchronous, active-high reset.
- vga_clk out 1: 25 MHz pixel clock to DAC.
- pix_en out 1: one-clk strobe, advances the pixel counters.
- hcnt out 10: horizontal count, 0..799.
- vcnt out 10: vertical count, 0..524.
- hsync_n out 1: horizontal sync, active low.
- vsync_n out 1: vertical sync, active low.
- blank_n out 1: high inside the visible area.
- sync_n out 1: composite sync, tied 0.
- line_end out 1: one-clk pulse on the last pixel of each line.
- frame_end out 1: one-clk pulse on the last pixel of each frame.
REQ-003 The block SHALL use the single clock clk; reset SHALL be synchronous and active-high; there SHALL be no other clock or asynchronous reset.

Function
REQ-004 Phase register ph SHALL toggle every clk cycle; pix_en SHALL equal ph; vga_clk SHALL equal ph, so vga_clk rises one clk after the counters change (mid-pixel).
REQ-005 hcnt SHALL increment by 1 only on clk edges where pix_en=1; at H_TOTAL-1 (799) it SHALL wrap to 0 on that edge.
REQ-006 vcnt SHALL increment only when pix_en=1 and hcnt=799; at V_TOTAL-1 (524) it SHALL wrap to 0 on that edge.
REQ-007 H_TOTAL and V_TOTAL SHALL be computed as the sums of the parameters; counter widths SHALL be 10 bits, with no overflow past the total.
REQ-008 hsync_n SHALL be 0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-009 vsync_n SHALL be 0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
REQ-010 blank_n SHALL be 1 iff hcnt<640 and vcnt<480.
REQ-011 hsync_n, vsync_n and blank_n SHALL be decoded from the registered counters with zero cycles of latency relative to hcnt/vcnt; they SHALL change only on edges where the counters change.
REQ-012 line_end SHALL be 1 exactly in the clk cycle where pix_en=1 and hcnt=799.
REQ-013 frame_end SHALL be 1 exactly in the clk cycle where pix_en=1, hcnt=799 and vcnt=524; the next counter state SHALL be (0,0).
REQ-014 The sync_n output SHALL be constant 0.
REQ-015 The totals SHALL be: 1600 clk per line and 840000 clk per frame.

Reset
REQ-016 While reset=1: ph=0, hcnt=0, vcnt=0, pix_en=0, vga_clk=0, hsync_n=1, vsync_n=1, blank_n=1, line_end=0, frame_end=0.
REQ-017 In the first cycle after reset deasserts, pix_en SHALL be 0; it SHALL be 1 in the second cycle; hcnt SHALL become 1 at the edge ending the second cycle.
REQ-018 Reset asserted mid-frame SHALL return all state to REQ-016 values on the next clk edge, with no partial line or pulse emitted afterwards.

Verification
REQ-019 Reset release: reset 1 for 3 cycles, then 0 -> pix_en pattern 0,1,0,1...; hcnt=1 after 2 clks, hcnt=2 after 4 clks.
REQ-020 Horizontal timing: run one line -> blank_n falls at hcnt=640; hsync_n low for exactly 192 clk (hcnt 656..751); line_end pulses once per 1600 clk.
REQ-021 Vertical timing: run one full frame -> vsync_n low for exactly 3200 clk (vcnt 490..491); blank_n stays 0 for vcnt 480..524.
REQ-022 Wrap: at hcnt=799, vcnt=524 with pix_en=1 -> frame_end=1 for one clk and the next counters are (0,0); frame_end spacing is 840000 clk.
REQ-023 Reset mid-line: assert reset at hcnt=700, vcnt=100 -> the next edge gives hcnt=0, vcnt=0, hsync_n=1, and restart behaviour identical to REQ-019.
REQ-024 Invariants (assertion): hcnt<800, vcnt<525, sync_n=0 at all times, and pix_en never high on two consecutive cycles.
